// File: rtl/debounce_multi_if.sv
// Bundles the per-channel pin inputs and the conditioned outputs of
// debounce_multi. The board side (master) drives the raw pins.
// The debouncer (slave) returns the levels and strobes.
interface debounce_multi_if #(
   parameter int CHANNELS = 4
);
   logic [CHANNELS-1:0] sig_in;      // raw asynchronous pin levels
   logic [CHANNELS-1:0] sig_out;     // debounced level, 1 = asserted
   logic [CHANNELS-1:0] rise;        // one-cycle strobe on sig_out 0->1
   logic [CHANNELS-1:0] fall;        // one-cycle strobe on sig_out 1->0
   logic [CHANNELS-1:0] long_press;  // one-cycle strobe after a long hold
   logic [CHANNELS-1:0] held;        // level from long_press until release

   modport master (
      output sig_in,
      input  sig_out, rise, fall, long_press, held
   );

   modport slave (
      input  sig_in,
      output sig_out, rise, fall, long_press, held
   );
endinterface

// File: rtl/debounce_multi.sv
// Multi-channel input conditioner for board-level buttons and switches.
// Each channel passes through a 2-FF synchroniser and a polarity fix.
// A consecutive-sample filter then accepts a new level only after
// DEBOUNCE_CYCLES disagreeing samples in a row. Edge strobes and an
// optional long-press detector are derived from the filtered level.
// There is no handshake: every output is a registered level or a
// one-cycle strobe.
module debounce_multi #(
   parameter int                  CHANNELS        = 4,
   parameter int                  DEBOUNCE_CYCLES = 250000,
   parameter int                  LONG_CYCLES     = 25000000,
   parameter logic [CHANNELS-1:0] INVERT          = '0
) (
   input  logic              clk25,
   input  logic              rst_n,
   debounce_multi_if.slave   bus
);

   localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   logic [CHANNELS-1:0] s1_q, s1_d;
   logic [CHANNELS-1:0] s2_q, s2_d;
   logic [CHANNELS-1:0] samp;
   logic [CHANNELS-1:0] sig_out_q, sig_out_d;
   logic [CHANNELS-1:0] rise_q, rise_d;
   logic [CHANNELS-1:0] fall_q, fall_d;
   logic [DB_W-1:0]     db_cnt_q [CHANNELS];
   logic [DB_W-1:0]     db_cnt_d [CHANNELS];

   // Synchroniser next-state; the polarity fix makes samp 1 = asserted.
   always_comb begin
      s1_d = bus.sig_in;
      s2_d = s1_q;
      samp = s2_q ^ INVERT;
   end

   // Debounce filter: count disagreeing samples and accept the new level
   // on the DEBOUNCE_CYCLES-th one. Any agreeing sample restarts the count.
   always_comb begin
      sig_out_d = sig_out_q;
      for (int i = 0; i < CHANNELS; i++) begin
         db_cnt_d[i] = '0;
         if (samp[i] != sig_out_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) begin
               sig_out_d[i] = samp[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
         end
      end
      rise_d = sig_out_d & ~sig_out_q;
      fall_d = ~sig_out_d & sig_out_q;
   end

   // Synchroniser, filter state and edge strobes. Reset loads the idle
   // pin level into the synchroniser, so leaving reset makes no strobes.
   always_ff @(posedge clk25) begin
      if (!rst_n) begin
         s1_q      <= INVERT;
         s2_q      <= INVERT;
         sig_out_q <= '0;
         rise_q    <= '0;
         fall_q    <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            db_cnt_q[i] <= '0;
         end
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         sig_out_q <= sig_out_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         for (int i = 0; i < CHANNELS; i++) begin
            db_cnt_q[i] <= db_cnt_d[i];
         end
      end
   end

   assign bus.sig_out = sig_out_q;
   assign bus.rise    = rise_q;
   assign bus.fall    = fall_q;

   if (LONG_CYCLES > 0) begin : g_long
      localparam int              LC_W    = $clog2(LONG_CYCLES + 1);
      localparam logic [LC_W-1:0] LC_LAST = LC_W'(LONG_CYCLES - 1);

      logic [LC_W-1:0]     lc_cnt_q [CHANNELS];
      logic [LC_W-1:0]     lc_cnt_d [CHANNELS];
      logic [CHANNELS-1:0] lp_q, lp_d;
      logic [CHANNELS-1:0] held_q, held_d;

      // Long-press timer. It restarts on every press and saturates once
      // it has fired. A press that ends on the very edge the timer would
      // expire counts as a short press, so fall and long_press never
      // coincide.
      always_comb begin
         for (int i = 0; i < CHANNELS; i++) begin
            lc_cnt_d[i] = lc_cnt_q[i];
            lp_d[i]     = 1'b0;
            held_d[i]   = held_q[i];
            if (!sig_out_d[i]) begin
               lc_cnt_d[i] = '0;
               held_d[i]   = 1'b0;
            end else if (!sig_out_q[i]) begin
               lc_cnt_d[i] = '0;
            end else if (!held_q[i]) begin
               if (lc_cnt_q[i] == LC_LAST) begin
                  lp_d[i]   = 1'b1;
                  held_d[i] = 1'b1;
               end else begin
                  lc_cnt_d[i] = lc_cnt_q[i] + 1'b1;
               end
            end
         end
      end

      // Long-press state register.
      always_ff @(posedge clk25) begin
         if (!rst_n) begin
            lp_q   <= '0;
            held_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
               lc_cnt_q[i] <= '0;
            end
         end else begin
            lp_q   <= lp_d;
            held_q <= held_d;
            for (int i = 0; i < CHANNELS; i++) begin
               lc_cnt_q[i] <= lc_cnt_d[i];
            end
         end
      end

      assign bus.long_press = lp_q;
      assign bus.held       = held_q;
   end else begin : g_no_long
      assign bus.long_press = '0;
      assign bus.held       = '0;
   end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi (2 channels, 4-sample debounce,
// 10-cycle long press, channel 1 active-low). An event-level reference
// model is checked against every output on every cycle. A few literal
// latencies and counts measured from the DUT pin the model down.
module tb_debounce_multi;

   localparam int            CH  = 2;
   localparam int            DB  = 4;
   localparam int            LC  = 10;
   localparam logic [CH-1:0] INV = 2'b10;
   localparam bit [31:0]     WMASK = (32'd1 << DB) - 32'd1;

   logic clk25 = 1'b0;
   logic rst_n = 1'b0;

   debounce_multi_if #(.CHANNELS(CH)) bus ();

   debounce_multi #(
      .CHANNELS(CH),
      .DEBOUNCE_CYCLES(DB),
      .LONG_CYCLES(LC),
      .INVERT(INV)
   ) dut (
      .clk25(clk25),
      .rst_n(rst_n),
      .bus(bus.slave)
   );

   // Clock and counters
   always #20 clk25 = ~clk25;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Reference model. The model works on the timeline of pin samples and
   // accepted edges:
   //  - a pin level is seen two edges after it is driven;
   //  - a new level is accepted once the last DB samples all disagree and
   //    at least DB edges have passed since the last accepted change or reset;
   //  - long_press fires LC edges after the press if the press is still on.
   logic [CH-1:0] m_p1, m_p2, m_out, m_rise, m_fall, m_lp, m_held;
   logic [CH-1:0] m_samp, m_nxt;
   bit   [31:0]   m_hist [CH];
   int            m_last_chg [CH];
   int            m_press [CH];
   bit            m_valid = 1'b0;

   // Event monitor, fed from DUT pins
   int            n_rise0, n_fall0, n_lp0, n_strobe;
   int            t_rise0, t_fall0, t_lp0;
   logic [CH-1:0] last_rise_vec;

   task automatic chk(input string name, input logic [CH-1:0] act,
                      input logic [CH-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d actual=%b expected=%b", name, cyc, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
      end
   endtask

   task automatic model_step();
      if (!rst_n) begin
         m_p1   = INV;
         m_p2   = INV;
         m_out  = '0;
         m_rise = '0;
         m_fall = '0;
         m_lp   = '0;
         m_held = '0;
         for (int i = 0; i < CH; i++) begin
            m_last_chg[i] = cyc;
            m_press[i]    = cyc;
         end
         m_valid = 1'b1;
      end else begin
         m_samp = m_p2 ^ INV;
         m_p2   = m_p1;
         m_p1   = bus.sig_in;
         for (int i = 0; i < CH; i++) begin
            m_hist[i] = {m_hist[i][30:0], m_samp[i]};
            m_nxt[i]  = m_out[i];
            if ((cyc - m_last_chg[i] >= DB) &&
                ((m_hist[i] & WMASK) == (m_out[i] ? 32'd0 : WMASK))) begin
               m_nxt[i]      = ~m_out[i];
               m_last_chg[i] = cyc;
            end
            m_rise[i] = m_nxt[i] & ~m_out[i];
            m_fall[i] = ~m_nxt[i] & m_out[i];
            m_lp[i]   = m_out[i] && m_nxt[i] && !m_held[i] &&
                        (cyc - m_press[i] == LC);
            m_held[i] = m_nxt[i] && (m_held[i] || m_lp[i]);
            if (m_rise[i]) m_press[i] = cyc;
            m_out[i] = m_nxt[i];
         end
      end
   endtask

   // Per-cycle compare and event monitor. It runs on the falling edge,
   // while the inputs still hold the values sampled at the rising edge.
   initial begin
      forever begin
         @(negedge clk25);
         cyc++;
         model_step();
         if (m_valid) begin
            chk("sig_out",    bus.sig_out,    m_out);
            chk("rise",       bus.rise,       m_rise);
            chk("fall",       bus.fall,       m_fall);
            chk("long_press", bus.long_press, m_lp);
            chk("held",       bus.held,       m_held);
         end
         if (bus.rise[0])       begin n_rise0++; t_rise0 = cyc; end
         if (bus.fall[0])       begin n_fall0++; t_fall0 = cyc; end
         if (bus.long_press[0]) begin n_lp0++;   t_lp0   = cyc; end
         if (|bus.rise) last_rise_vec = bus.rise;
         if (|{bus.rise, bus.fall, bus.long_press}) n_strobe++;
      end
   end

   // Driver tasks
   task automatic step();
      @(negedge clk25);
      #1;
   endtask

   task automatic clr();
      n_rise0 = 0; n_fall0 = 0; n_lp0 = 0; n_strobe = 0;
      t_rise0 = 0; t_fall0 = 0; t_lp0 = 0;
      last_rise_vec = '0;
   endtask

   // which: 0 rise0, 1 long_press0, 2 fall0, 3 any strobe, 4 held0
   task automatic wait_ev(input int which, input int limit, input string name);
      bit hit;
      hit = 1'b0;
      for (int k = 0; k < limit && !hit; k++) begin
         step();
         case (which)
            0:       hit = (n_rise0 > 0);
            1:       hit = (n_lp0 > 0);
            2:       hit = (n_fall0 > 0);
            3:       hit = (n_strobe > 0);
            default: hit = (bus.held[0] === 1'b1);
         endcase
      end
      if (!hit) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s timeout after %0d cycles, event required", name, limit);
      end
   endtask

   int e;
   int x;

   // Directed stimulus
   initial begin
      bus.sig_in = INV;
      rst_n      = 1'b0;
      clr();
      repeat (3) step();
      rst_n = 1'b1;

      // Reset exit with idle pins: quiet for 50 cycles
      clr();
      repeat (50) step();
      chk_int("idle_strobes", n_strobe, 0);
      chk("idle_sig_out", bus.sig_out, 2'b00);
      chk("idle_held", bus.held, 2'b00);

      // Glitch of 3 cycles is rejected
      clr();
      bus.sig_in[0] = 1'b1;
      repeat (3) step();
      bus.sig_in[0] = 1'b0;
      repeat (15) step();
      chk_int("glitch3_rise", n_rise0, 0);
      chk("glitch3_out", bus.sig_out, 2'b00);

      // Pulse of 4 cycles is accepted once
      clr();
      bus.sig_in[0] = 1'b1;
      repeat (4) step();
      bus.sig_in[0] = 1'b0;
      repeat (15) step();
      chk_int("pulse4_rise", n_rise0, 1);
      chk_int("pulse4_fall", n_fall0, 1);
      chk_int("pulse4_lp", n_lp0, 0);

      // Clean press: rise five edges after the pin is captured
      clr();
      bus.sig_in[0] = 1'b1;
      e = cyc + 1;
      wait_ev(0, 30, "press_rise");
      chk_int("press_latency", t_rise0 - e, 5);

      // Long press ten cycles after rise, exactly once
      wait_ev(1, 40, "long_press");
      chk_int("long_latency", t_lp0 - t_rise0, 10);
      chk("long_held", bus.held, 2'b01);
      repeat (20) step();
      chk_int("long_once", n_lp0, 1);
      chk("long_held_still", bus.held, 2'b01);

      // Release: fall five edges after capture, held drops with it
      bus.sig_in[0] = 1'b0;
      e = cyc + 1;
      wait_ev(2, 30, "release_fall");
      chk_int("release_latency", t_fall0 - e, 5);
      chk("release_held", bus.held, 2'b00);
      repeat (10) step();
      chk_int("release_fall_once", n_fall0, 1);

      // Nine-cycle hold: no long press
      clr();
      bus.sig_in[0] = 1'b1;
      repeat (9) step();
      bus.sig_in[0] = 1'b0;
      repeat (25) step();
      chk_int("hold9_rise", n_rise0, 1);
      chk_int("hold9_fall", n_fall0, 1);
      chk_int("hold9_lp", n_lp0, 0);

      // Active-low channel 1 pressed together with channel 0
      clr();
      bus.sig_in = 2'b01;
      wait_ev(3, 30, "both_rise");
      chk("both_rise_vec", last_rise_vec, 2'b11);
      chk("both_sig_out", bus.sig_out, 2'b11);
      bus.sig_in = INV;
      repeat (30) step();
      chk("both_released", bus.sig_out, 2'b00);

      // Reset while channel 0 is held: no fall, then re-debounce
      clr();
      bus.sig_in[0] = 1'b1;
      wait_ev(4, 40, "held_before_reset");
      rst_n = 1'b0;
      step();
      x = cyc;
      chk("rst_sig_out", bus.sig_out, 2'b00);
      chk("rst_held", bus.held, 2'b00);
      chk("rst_fall", bus.fall, 2'b00);
      rst_n = 1'b1;
      clr();
      wait_ev(0, 30, "post_reset_rise");
      chk_int("post_reset_latency", t_rise0 - x, 6);
      chk_int("post_reset_no_fall", n_fall0, 0);
      bus.sig_in[0] = 1'b0;
      repeat (30) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
